cpu_seq_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RISC core. Fetches 49-bit instructions over an instruction-memory
//  req/ack port, holds them in the IR that feeds the instruction decoder, and sequences the ALU,

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/seq_timeout_ctr.sv | 29 ++
 rtl/cpu_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC control sequencer: opcodes, modes, FSM states
// and instruction field positions.
package cpu_pkg;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_LD  = 5'h01;
  localparam logic [4:0] OP_ST  = 5'h02;
  localparam logic [4:0] OP_HLT = 5'h1F;

  localparam logic [1:0] MD_IMM = 2'b00;
  localparam logic [1:0] MD_DIR = 2'b01;
  localparam logic [1:0] MD_REG = 2'b10;
  localparam logic [1:0] MD_RSV = 2'b11;

  localparam int OP_HI  = 48;
  localparam int OP_LO  = 44;
  localparam int MD_HI  = 43;
  localparam int MD_LO  = 42;
  localparam int SRC_HI = 41;
  localparam int SRC_LO = 37;
  localparam int DST_HI = 36;
  localparam int DST_LO = 32;
  localparam int LIT_HI = 31;
  localparam int LIT_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALTED
  } state_t;

  // Stores always touch data RAM; loads only in direct mode.
  function automatic logic is_mem_op(input logic [4:0] op, input logic [1:0] md);
    return (op == OP_ST) || ((op == OP_LD) && (md == MD_DIR));
  endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Bus wait counter shared by the fetch and data-memory wait states; expire is
// raised once TIMEOUT-1 unacknowledged cycles have been counted.
module seq_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  assign expire = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle control FSM: fetches into the IR, sequences ALU / data RAM /
// register-file strobes per opcode, and owns PC, bus timeouts and halt.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int IW      = 49,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_data,
  output logic [IW-1:0]   ir,
  output logic            alu_en,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            reg_we,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            bus_err,
  output logic            illegal
);

  state_t state, state_next;

  logic       pc_inc, pc_clr, ir_load, set_bus_err, set_illegal;
  logic       waiting, ack_now, expire;
  logic [4:0] op;
  logic [1:0] md;

  assign op        = ir[OP_HI:OP_LO];
  assign md        = ir[MD_HI:MD_LO];
  assign imem_addr = pc;
  assign busy      = (state != ST_IDLE) && (state != ST_HALTED);
  assign halted    = (state == ST_HALTED);

  // The counter restarts from zero on every entry into a wait state.
  assign waiting = (state == ST_FETCH) || (state == ST_MEM);
  assign ack_now = ((state == ST_FETCH) && imem_ack) || ((state == ST_MEM) && dmem_ack);

  seq_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!waiting || ack_now),
    .en    (waiting),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    alu_en      = 1'b0;
    reg_we      = 1'b0;
    pc_inc      = 1'b0;
    pc_clr      = 1'b0;
    ir_load     = 1'b0;
    set_bus_err = 1'b0;
    set_illegal = 1'b0;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_clr     = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load    = 1'b1;
          state_next = ST_DECODE;
        end else if (expire) begin
          set_bus_err = 1'b1;
          state_next  = ST_HALTED;
        end
      end
      ST_DECODE: begin
        if (op == OP_HLT) begin
          state_next = ST_HALTED;
        end else if (md == MD_RSV) begin
          set_illegal = 1'b1;
          pc_inc      = 1'b1;
          state_next  = ST_FETCH;
        end else if (op == OP_NOP) begin
          pc_inc     = 1'b1;
          state_next = ST_FETCH;
        end else if (is_mem_op(op, md)) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_en     = 1'b1;
        state_next = ST_WB;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_ST);
        if (dmem_ack) begin
          if (op == OP_ST) begin
            pc_inc     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (expire) begin
          set_bus_err = 1'b1;
          state_next  = ST_HALTED;
        end
      end
      ST_WB: begin
        reg_we     = 1'b1;
        pc_inc     = 1'b1;
        state_next = ST_FETCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Start clears the sticky flags along with the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      bus_err <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (pc_clr) begin
        pc <= '0;
      end else if (pc_inc) begin
        pc <= pc + 1'b1;
      end
      if (ir_load) begin
        ir <= imem_data;
      end
      if (pc_clr) begin
        bus_err <= 1'b0;
      end else if (set_bus_err) begin
        bus_err <= 1'b1;
      end
      if (pc_clr) begin
        illegal <= 1'b0;
      end else if (set_illegal) begin
        illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl with behavioural instruction/data memories
// whose ack latency is set per test (negative latency = never acknowledge).
module tb_cpu_seq_ctrl;
  import cpu_pkg::*;

  localparam int PC_W    = 8;
  localparam int IW      = 49;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [IW-1:0]   imem_data = '0;
  logic [IW-1:0]   ir;
  logic            alu_en;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack = 1'b0;
  logic            reg_we;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
  logic            bus_err;
  logic            illegal;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] imem [0:255];
  int imem_delay = 0;
  int dmem_delay = 0;
  int iwait = 0;
  int dwait = 0;

  always #5 clk = ~clk;

  cpu_seq_ctrl #(
    .PC_W(PC_W), .IW(IW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ir(ir), .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .reg_we(reg_we), .pc(pc), .busy(busy), .halted(halted), .bus_err(bus_err), .illegal(illegal)
  );

  // Memory responders: ack after a programmable number of requested cycles.
  always @(negedge clk) begin
    if (imem_req) begin
      imem_data = imem[imem_addr];
      imem_ack  = (imem_delay >= 0) && (iwait >= imem_delay);
      iwait     = imem_ack ? 0 : iwait + 1;
    end else begin
      imem_ack = 1'b0;
      iwait    = 0;
    end
    if (dmem_req) begin
      dmem_ack = (dmem_delay >= 0) && (dwait >= dmem_delay);
      dwait    = dmem_ack ? 0 : dwait + 1;
    end else begin
      dmem_ack = 1'b0;
      dwait    = 0;
    end
  end

  function automatic logic [IW-1:0] mk(input logic [4:0] op, input logic [1:0] md);
    return {op, md, 5'd1, 5'd2, 32'h1234_5678};
  endfunction

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) imem[i] = mk(OP_NOP, MD_IMM);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the first FETCH cycle after the pulse.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, alu_en, dmem_req, dmem_we, reg_we, busy, halted, bus_err, illegal} !== 9'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 000000000",
               {imem_req, alu_en, dmem_req, dmem_we, reg_we, busy, halted, bus_err, illegal});
    end
    checks++;
    if (pc !== 8'h00 || ir !== '0 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_regs: pc=%h ir=%h addr=%h expected all zero", pc, ir, imem_addr);
    end
    $display("test_reset done");
  endtask

  task automatic test_alu();
    apply_reset();
    fill_nop();
    imem[0] = mk(5'h04, MD_REG);
    imem_delay = 0;
    pulse_start();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL alu_fetch: req=%b addr=%h busy=%b expected 1 00 1", imem_req, imem_addr, busy);
    end
    @(negedge clk);
    checks++;
    if (ir !== mk(5'h04, MD_REG) || {alu_en, reg_we, dmem_req} !== 3'b000) begin
      errors++;
      $display("FAIL alu_decode: ir=%h strobes=%b expected %h 000", ir, {alu_en, reg_we, dmem_req}, mk(5'h04, MD_REG));
    end
    @(negedge clk);
    checks++;
    if ({alu_en, reg_we, dmem_req} !== 3'b100) begin
      errors++;
      $display("FAIL alu_exec_cycle3: strobes=%b expected 100", {alu_en, reg_we, dmem_req});
    end
    @(negedge clk);
    checks++;
    if ({alu_en, reg_we, dmem_req} !== 3'b010 || pc !== 8'h00) begin
      errors++;
      $display("FAIL alu_wb_cycle4: strobes=%b pc=%h expected 010 00", {alu_en, reg_we, dmem_req}, pc);
    end
    @(negedge clk);
    checks++;
    if (pc !== 8'h01 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL alu_next_pc: pc=%h req=%b expected 01 1", pc, imem_req);
    end
    $display("test_alu done");
  endtask

  task automatic test_store();
    logic found;
    int nreq, nwe, nreg;
    apply_reset();
    fill_nop();
    imem[5] = mk(OP_ST, MD_DIR);
    imem_delay = 0;
    dmem_delay = 3;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && imem_addr == 8'h05) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL st_reach_pc5: pc=%h expected fetch at 05", pc);
    end
    @(negedge clk);
    nreq = 0; nwe = 0; nreg = 0;
    repeat (4) begin
      @(negedge clk);
      nreq += int'(dmem_req);
      nwe  += int'(dmem_req && dmem_we);
      nreg += int'(reg_we);
    end
    checks++;
    if (nreq != 4 || nwe != 4) begin
      errors++;
      $display("FAIL st_req_held: req_cycles=%0d we_cycles=%0d expected 4 4", nreq, nwe);
    end
    checks++;
    if (nreg != 0) begin
      errors++;
      $display("FAIL st_no_reg_we: reg_we_cycles=%0d expected 0", nreg);
    end
    @(negedge clk);
    checks++;
    if (pc !== 8'h06 || imem_req !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL st_next_pc: pc=%h ireq=%b dreq=%b expected 06 1 0", pc, imem_req, dmem_req);
    end
    dmem_delay = 0;
    $display("test_store done");
  endtask

  task automatic test_back_to_back_loads();
    apply_reset();
    fill_nop();
    imem[0] = mk(OP_LD, MD_DIR);
    imem[1] = mk(OP_LD, MD_IMM);
    imem_delay = 0;
    dmem_delay = 0;
    pulse_start();
    repeat (2) @(negedge clk);
    checks++;
    if ({alu_en, reg_we, dmem_req, dmem_we} !== 4'b0010) begin
      errors++;
      $display("FAIL ld_dir_mem: alu,reg,dreq,we=%b expected 0010", {alu_en, reg_we, dmem_req, dmem_we});
    end
    @(negedge clk);
    checks++;
    if ({alu_en, reg_we, dmem_req} !== 3'b010) begin
      errors++;
      $display("FAIL ld_dir_wb: strobes=%b expected 010", {alu_en, reg_we, dmem_req});
    end
    @(negedge clk);
    checks++;
    if (pc !== 8'h01 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL ld_dir_next: pc=%h req=%b expected 01 1", pc, imem_req);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({alu_en, reg_we, dmem_req} !== 3'b100) begin
      errors++;
      $display("FAIL ld_imm_exec: strobes=%b expected 100", {alu_en, reg_we, dmem_req});
    end
    @(negedge clk);
    checks++;
    if ({alu_en, reg_we, dmem_req} !== 3'b010) begin
      errors++;
      $display("FAIL ld_imm_wb: strobes=%b expected 010", {alu_en, reg_we, dmem_req});
    end
    @(negedge clk);
    checks++;
    if (pc !== 8'h02) begin
      errors++;
      $display("FAIL ld_imm_next: pc=%h expected 02", pc);
    end
    $display("test_back_to_back_loads done");
  endtask

  task automatic test_wrap_halt();
    logic found;
    apply_reset();
    fill_nop();
    imem_delay = 0;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (imem_req && imem_addr == 8'hFF) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wrap_reach_ff: pc=%h expected fetch at ff", pc);
    end
    imem[1] = mk(OP_HLT, MD_IMM);
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== 8'h00 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pc: pc=%h req=%b expected 00 1", pc, imem_req);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'h01 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL hlt_state: halted=%b busy=%b pc=%h req=%b expected 1 0 01 0", halted, busy, pc, imem_req);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || pc !== 8'h01) begin
      errors++;
      $display("FAIL hlt_stays: halted=%b pc=%h expected 1 01", halted, pc);
    end
    pulse_start();
    checks++;
    if (pc !== 8'h00 || imem_req !== 1'b1 || halted !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hlt_restart: pc=%h req=%b halted=%b busy=%b expected 00 1 0 1", pc, imem_req, halted, busy);
    end
    $display("test_wrap_halt done");
  endtask

  task automatic test_timeout();
    apply_reset();
    fill_nop();
    imem_delay = -1;
    pulse_start();
    repeat (TIMEOUT - 1) @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL to_last_wait: req=%b bus_err=%b expected 1 0", imem_req, bus_err);
    end
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_expired: bus_err=%b halted=%b req=%b busy=%b expected 1 1 0 0", bus_err, halted, imem_req, busy);
    end
    imem_delay = TIMEOUT - 1;
    pulse_start();
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL to_start_clears: bus_err=%b expected 0", bus_err);
    end
    repeat (TIMEOUT) @(negedge clk);
    checks++;
    if (bus_err !== 1'b0 || halted !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_ack_last: bus_err=%b halted=%b busy=%b expected 0 0 1", bus_err, halted, busy);
    end
    @(negedge clk);
    checks++;
    if (pc !== 8'h01 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL to_ack_next: pc=%h req=%b expected 01 1", pc, imem_req);
    end
    imem_delay = 0;
    $display("test_timeout done");
  endtask

  task automatic test_illegal_reset();
    apply_reset();
    fill_nop();
    imem[0] = mk(5'h04, MD_RSV);
    imem[1] = mk(OP_ST, MD_DIR);
    imem_delay = 0;
    dmem_delay = -1;
    pulse_start();
    @(negedge clk);
    checks++;
    if ({alu_en, reg_we, dmem_req} !== 3'b000 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL ill_decode: strobes=%b illegal=%b expected 000 0", {alu_en, reg_we, dmem_req}, illegal);
    end
    @(negedge clk);
    checks++;
    if (illegal !== 1'b1 || pc !== 8'h01 || imem_req !== 1'b1 || {alu_en, reg_we, dmem_req} !== 3'b000) begin
      errors++;
      $display("FAIL ill_flag: illegal=%b pc=%h req=%b strobes=%b expected 1 01 1 000",
               illegal, pc, imem_req, {alu_en, reg_we, dmem_req});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_mem: dreq=%b we=%b expected 1 1", dmem_req, dmem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, alu_en, dmem_req, dmem_we, reg_we, busy, halted, bus_err, illegal} !== 9'b0 || pc !== 8'h00 || ir !== '0) begin
      errors++;
      $display("FAIL async_reset: outs=%b pc=%h ir=%h expected all zero",
               {imem_req, alu_en, dmem_req, dmem_we, reg_we, busy, halted, bus_err, illegal}, pc, ir);
    end
    @(negedge clk) rst_n = 1'b1;
    dmem_delay = 0;
    $display("test_illegal_reset done");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fill_nop();
    test_reset();
    test_alu();
    test_store();
    test_back_to_back_loads();
    test_wrap_halt();
    test_timeout();
    test_illegal_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
